// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int DEF_ADDR_WIDTH = 30;
    localparam int DEF_DATA_WIDTH = 32;

    // Request bundle at the default port widths.
    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic valid;
        logic id;
    } read_tag_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Two-stage {valid, id} delay line that turns a read handshake into a tagged rvalid pulse.
module read_tag_pipe
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_id,
    output logic rvalid0,
    output logic rvalid1
);

    read_tag_t stage1_q;
    read_tag_t stage2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= '{valid: in_valid, id: in_id};
            stage2_q <= stage1_q;
        end
    end

    assign rvalid0 = stage2_q.valid && (stage2_q.id == REQ_CPU);
    assign rvalid1 = stage2_q.valid && (stage2_q.id == REQ_DMA);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with burst limit sharing one registered memory command port
// between the CPU and a DMA requester.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic               owner_q, owner_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] gnt_vec;
    logic               req_own, req_oth, hs, rd_hs;
    req_t               sel;

    assign req_vec = {req1, req0};

    always_comb begin
        gnt_vec = '0;
        gnt_vec[owner_q] = req_vec[owner_q];
        req_own = req_vec[owner_q];
        req_oth = req_vec[~owner_q];
        hs      = req_own;
        sel     = (owner_q == REQ_CPU) ? '{we: we0, addr: addr0, wdata: wdata0}
                                       : '{we: we1, addr: addr1, wdata: wdata1};
        rd_hs   = hs && !sel.we;
    end

    assign gnt0 = gnt_vec[REQ_CPU];
    assign gnt1 = gnt_vec[REQ_DMA];

    // A hand-off at the burst limit happens on the owner's last handshake, so no bubble;
    // an idle owner only yields on the following edge, which costs one cycle.
    always_comb begin
        owner_d = owner_q;
        burst_d = burst_q;
        if (hs && req_oth && (burst_q == BURST_LAST)) begin
            owner_d = ~owner_q;
            burst_d = '0;
        end else if (hs) begin
            burst_d = (burst_q == BURST_LAST) ? burst_q : burst_q + 1'b1;
        end else if (!req_own && req_oth) begin
            owner_d = ~owner_q;
            burst_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= REQ_CPU;
            burst_q   <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
            mem_re  <= rd_hs;
            mem_we  <= hs && sel.we;
            if (hs) begin
                mem_addr  <= sel.addr;
                mem_wdata <= sel.wdata;
            end
        end
    end

    assign rdata = mem_rdata;

    read_tag_pipe u_read_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_valid (rd_hs),
        .in_id    (owner_q),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected commands/read returns queued at handshake time.
module tb_mem_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_re, mem_we;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int            due;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } rd_t;

    cmd_t cmd_q[$];
    rd_t  rd_q[$];

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 30'h10) return 32'hDEAD_BEEF;
        return {2'b10, a} ^ 32'h0F0F_0000;
    endfunction

    // Zero-wait synchronous memory
    always @(posedge clk) mem_rdata <= mem_re ? mem_fn(mem_addr) : 32'h0;

    // Scoreboard: pop and compare whatever is due this cycle, otherwise expect idle
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
                cmd_t c;
                c = cmd_q.pop_front();
                if (mem_re !== !c.we || mem_we !== c.we || mem_addr !== c.addr ||
                    (c.we && mem_wdata !== c.wdata))
                begin
                    failures++;
                    $display("FAIL mem_cmd cyc=%0d got re=%0b we=%0b addr=%h wdata=%h want re=%0b we=%0b addr=%h wdata=%h",
                             cyc, mem_re, mem_we, mem_addr, mem_wdata, !c.we, c.we, c.addr, c.wdata);
                end
            end else if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
                failures++;
                $display("FAIL mem_idle cyc=%0d got re=%0b we=%0b want re=0 we=0", cyc, mem_re, mem_we);
            end
            checks++;
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                rd_t r;
                r = rd_q.pop_front();
                if (rvalid0 !== (r.id == 1'b0) || rvalid1 !== (r.id == 1'b1) || rdata !== r.data) begin
                    failures++;
                    $display("FAIL rd_return cyc=%0d got rv0=%0b rv1=%0b rdata=%h want id=%0d rdata=%h",
                             cyc, rvalid0, rvalid1, rdata, r.id, r.data);
                end
            end else if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                failures++;
                $display("FAIL rd_idle cyc=%0d got rv0=%0b rv1=%0b want 0 0", cyc, rvalid0, rvalid1);
            end
        end
    end

    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic push_hs(input logic id, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        cmd_q.push_back('{due: cyc + 1, we: w, addr: a, wdata: d});
        if (!w) rd_q.push_back('{due: cyc + 2, id: id, data: mem_fn(a)});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        repeat (n) next_cycle();
    endtask

    task automatic do_reset(input int n);
        mon_en = 1'b0;
        reset  = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        repeat (n) next_cycle();
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(3);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 ||
            rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0)
        begin
            failures++;
            $display("FAIL reset_state got gnt=%0b%0b re=%0b we=%0b rv=%0b%0b addr=%h wdata=%h want all 0",
                     gnt1, gnt0, mem_re, mem_we, rvalid1, rvalid0, mem_addr, mem_wdata);
        end
        next_cycle();
    endtask

    task automatic test_cpu_read();
        drive(1, 0, 30'h10, '0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_gnt got gnt0=%0b gnt1=%0b want 1 0", gnt0, gnt1);
        end
        push_hs(0, 0, 30'h10, '0);
        next_cycle();
        idle_cycles(3);
    endtask

    task automatic test_round_robin();
        do_reset(2);
        drive(1, 0, 30'h100, '0, 1, 0, 30'h200, '0);
        for (int k = 0; k < 16; k++) begin
            logic exp_own;
            exp_own = ((k / 4) % 2) == 1;
            @(negedge clk);
            checks++;
            if (gnt0 !== !exp_own || gnt1 !== exp_own) begin
                failures++;
                $display("FAIL rr_gnt k=%0d got gnt0=%0b gnt1=%0b want gnt0=%0b gnt1=%0b",
                         k, gnt0, gnt1, !exp_own, exp_own);
            end
            push_hs(exp_own, 0, exp_own ? 30'h200 : 30'h100, '0);
            next_cycle();
        end
        idle_cycles(3);
    endtask

    task automatic test_dma_write();
        do_reset(2);
        drive(0, 0, '0, '0, 1, 1, 30'h3FFF_FFFF, 32'hA5A5_A5A5);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL dma_bubble got gnt0=%0b gnt1=%0b want 0 0", gnt0, gnt1);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL dma_gnt got gnt0=%0b gnt1=%0b want 0 1", gnt0, gnt1);
        end
        push_hs(1, 1, 30'h3FFF_FFFF, 32'hA5A5_A5A5);
        next_cycle();
        idle_cycles(4);
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        do_reset(2);
        drive(1, 0, 30'h4, '0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gnt_rd got gnt0=%0b want 1", gnt0);
        end
        push_hs(0, 0, 30'h4, '0);
        next_cycle();
        drive(1, 1, 30'h8, 32'h1234_5678, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gnt_wr got gnt0=%0b want 1", gnt0);
        end
        if (rvalid0 === 1'b1) pulses++;
        push_hs(0, 1, 30'h8, 32'h1234_5678);
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rvalid0 === 1'b1) pulses++;
            next_cycle();
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL b2b_rvalid_count got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        drive(1, 0, 30'h20, '0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_gnt got gnt0=%0b want 1", gnt0);
        end
        next_cycle();
        mon_en = 1'b0;
        reset  = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        next_cycle();
        @(negedge clk);
        checks++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_mem_re got re=%0b we=%0b want 0 0", mem_re, mem_we);
        end
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_rvalid k=%0d got rv0=%0b rv1=%0b want 0 0", k, rvalid0, rvalid1);
            end
            next_cycle();
        end
        drive(1, 0, 30'h30, '0, 1, 0, 30'h40, '0);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_owner got gnt0=%0b gnt1=%0b want 1 0", gnt0, gnt1);
        end
        next_cycle();
        idle_cycles(3);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        #1;
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_dma_write();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (cmd_q.size() != 0 || rd_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got cmd=%0d rd=%0d want 0 0", cmd_q.size(), rd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single word-addressed memory port between the CPU and one secondary requester (DMA/loader).
- Arbitration is round-robin with a burst limit.
- The memory command is registered.
- Read data returns with a per-requester valid tag.
- The CPU control gates its memory steps on grant; the memory side connects directly to the external rdata/wdata/addr/re/we pins.

Parameters:
ADDR_WIDTH, 30, word address width
DATA_WIDTH, 32, data width
MAX_BURST, 4, max consecutive handshakes by the owner while the other requester waits (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req0  in  1  CPU request valid
we0  in  1  CPU write (1) / read (0)
addr0  in  ADDR_WIDTH  CPU word address
wdata0  in  DATA_WIDTH  CPU write data
gnt0  out  1  CPU request accepted this cycle
rvalid0  out  1  CPU read data valid on rdata
req1  in  1  DMA request valid
we1  in  1  DMA write / read
addr1  in  ADDR_WIDTH  DMA word address
wdata1  in  DATA_WIDTH  DMA write data
gnt1  out  1  DMA request accepted this cycle
rvalid1  out  1  DMA read data valid on rdata
rdata  out  DATA_WIDTH  read return data (shared)
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_re

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset values: owner=0 (CPU), burst_cnt=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid0=rvalid1=0, read tag pipeline cleared.
- Grant and handshake:
  - gnt_i = req_i && (owner==i). Combinational from the owner register.
  - A handshake occurs at an edge where req_i && gnt_i.
  - Requester holds we/addr/wdata stable while req_i && !gnt_i.
- Memory command: registered. On a handshake edge, mem_re=!we_i, mem_we=we_i, and mem_addr/mem_wdata take requester i values for exactly one cycle. With no handshake: mem_re=mem_we=0, addr/wdata hold.
- Read return:
  - Tag {valid, id} is registered alongside mem_re, then delayed one more stage.
  - rvalid_id=1 for one cycle, two cycles after the handshake edge.
  - rdata = mem_rdata (passthrough) in that cycle.
  - Writes produce no rvalid.
- Throughput: one handshake per cycle; back-to-back handshakes by the same owner are allowed.
- Owner / burst counter update at each edge, where o = current owner and other = !o:
  - If req_o handshake and req_other=1 and burst_cnt==MAX_BURST-1: owner<=other, burst_cnt<=0. The other requester gets gnt next cycle with no bubble.
  - Else if req_o handshake: burst_cnt<=min(burst_cnt+1, MAX_BURST-1). It saturates while the other is idle.
  - Else if !req_o and req_other: owner<=other, burst_cnt<=0. This costs one bubble cycle.
  - Else: hold.
- Simultaneous first requests after reset: CPU wins (owner resets to 0).
- The non-owner never sees gnt, even if its req is high.
- Reset mid-operation: a pending read tag is dropped (no rvalid), mem_re/mem_we are deasserted the following cycle, and the owner returns to the CPU.
- Memory assumption: zero-wait synchronous memory (read data valid the cycle after mem_re); no backpressure from memory.

Decomposition:
- Package mem_arb_pkg:
  - localparam NUM_REQ=2.
  - Requester id constants REQ_CPU=1'b0, REQ_DMA=1'b1.
  - Packed struct type for a request {we, addr, wdata}.
- One sub-module: read_tag_pipe, a 2-stage {valid, id} shift register with synchronous clear, producing rvalid0/rvalid1.
- Grant/owner/burst logic and the command register stay in mem_arbiter.

Test Plan:
- Reset held 3 cycles, then released with no reqs -> gnt0=gnt1=0, mem_re=mem_we=0, rvalid0=rvalid1=0; the first req0 is granted in the same cycle.
- CPU read alone: req0=1, we0=0, addr0=0x10; memory returns 0xDEADBEEF.
  -> gnt0=1 at cycle t; mem_re=1, mem_addr=0x10 at t+1; rvalid0=1, rdata=0xDEADBEEF at t+2; rvalid1 stays 0.
- Both requesting reads continuously, MAX_BURST=4 -> grant pattern is 4x gnt0 then 4x gnt1, repeating, with no idle cycles.
  - mem_re stays high every cycle.
  - rvalid ids follow the same pattern delayed 2 cycles.
- DMA write while CPU idle: req1=1, we1=1, addr1=0x3FFFFFFF, wdata1=0xA5A5A5A5.
  -> one bubble, then gnt1; next cycle mem_we=1 with that address and data; no rvalid.
- CPU read at 0x4 then a back-to-back write to 0x8 -> mem_re then mem_we on consecutive cycles; exactly one rvalid0 pulse, aligned to the read.
- Reset asserted the cycle after a CPU read handshake -> no rvalid0 ever appears; mem_re=0 and owner=CPU after reset.
